// File: rtl/escritor_banco_registros.sv
`default_nettype none
// ============================================================================
// Module   : escritor_banco_registros
// Purpose  : FIFO write-back front end for the register bank. It forwards the
//            youngest queued value for each read port. ZERO_REG_DROP_EN makes
//            writes to register 0 complete their handshake and then be dropped.
// Revision : 1.0 - initial release
// ============================================================================
module escritor_banco_registros #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_data,
  input  logic                 br_hold,
  output logic [ADDR_W-1:0]    WA,
  output logic [DATA_W-1:0]    dataIn,
  output logic                 WE,
  input  logic [ADDR_W-1:0]    RA_A,
  input  logic [ADDR_W-1:0]    RA_B,
  output logic                 fwd_hit_a,
  output logic                 fwd_hit_b,
  output logic [DATA_W-1:0]    fwd_data_a,
  output logic [DATA_W-1:0]    fwd_data_b,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 idle
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_fifo_addr [DEPTH];
  logic [DATA_W-1:0]  r_fifo_data [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_we;
  logic [ADDR_W-1:0]  r_wa;
  logic [DATA_W-1:0]  r_data_in;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_count == c_CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign w_accept  = req_valid && !w_full;
`ifdef ZERO_REG_DROP_EN
  assign w_push    = w_accept && (req_addr != '0);
`else
  assign w_push    = w_accept;
`endif
  assign w_pop     = !w_empty && !br_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_data_in <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      r_we <= w_pop;
      if (w_pop) begin
        r_wa      <= r_fifo_addr[r_head];
        r_data_in <= r_fifo_data[r_head];
      end
    end
  end

  // Storage needs no reset: entries are qualified by the head/count window.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_tail] <= req_addr;
      r_fifo_data[r_tail] <= req_data;
    end
  end

  // Scan oldest to youngest so the last match (closest to the tail) wins.
  always_comb begin
    logic [c_PTR_W-1:0] v_idx;
    v_idx      = '0;
    pending    = '0;
    fwd_hit_a  = r_we && (r_wa == RA_A);
    fwd_hit_b  = r_we && (r_wa == RA_B);
    fwd_data_a = (r_we && (r_wa == RA_A)) ? r_data_in : '0;
    fwd_data_b = (r_we && (r_wa == RA_B)) ? r_data_in : '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_head + c_PTR_W'(k);
      if (c_CNT_W'(k) < r_count) begin
        pending[r_fifo_addr[v_idx]] = 1'b1;
        if (r_fifo_addr[v_idx] == RA_A) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = r_fifo_data[v_idx];
        end
        if (r_fifo_addr[v_idx] == RA_B) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = r_fifo_data[v_idx];
        end
      end
    end
`ifdef ZERO_REG_DROP_EN
    if (RA_A == '0) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
    if (RA_B == '0) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
`endif
  end

  assign WA     = r_wa;
  assign dataIn = r_data_in;
  assign WE     = r_we;
  assign idle   = w_empty && !r_we;

endmodule
`default_nettype wire

// File: tb/tb_escritor_banco_registros.sv
`default_nettype none
// ============================================================================
// Module   : tb_escritor_banco_registros
// Purpose  : Scoreboard bench for escritor_banco_registros (honours ZERO_REG_DROP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_escritor_banco_registros;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              br_hold;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] dataIn;
  logic              WE;
  logic [ADDR_W-1:0] RA_A;
  logic [ADDR_W-1:0] RA_B;
  logic              fwd_hit_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic [31:0]       pending;
  logic              idle;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  escritor_banco_registros #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .br_hold(br_hold),
    .WA(WA), .dataIn(dataIn), .WE(WE), .RA_A(RA_A), .RA_B(RA_B),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .pending(pending), .idle(idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every bank write must match the oldest outstanding accepted request.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && WE === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got WA=%0d dataIn=%0h expected no write", WA, dataIn);
      end else begin
        e = sb.pop_front();
        if (WA !== e.a || dataIn !== e.d) begin
          n_fail++;
          $display("FAIL bank_write: got WA=%0d dataIn=%0h expected WA=%0d dataIn=%0h",
                   WA, dataIn, e.a, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (req_ready) begin
`ifdef ZERO_REG_DROP_EN
        if (a != '0) sb.push_back('{a: a, d: d});
`else
        sb.push_back('{a: a, d: d});
`endif
        done = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (idle && sb.size() == 0) ok = 1'b1;
      else tick();
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    br_hold = 1'b0; RA_A = '0; RA_B = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_we", 64'(WE), 64'd0);
    chk("rst_wa", 64'(WA), 64'd0);
    chk("rst_datain", 64'(dataIn), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_hit_a", 64'(fwd_hit_a), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single write: one-cycle WE pulse one edge after acceptance
    send(5'd5, 32'hDEADBEEF);
    #1;
    chk("single_pending_t", 64'(pending), 64'h20);
    chk("single_we_t", 64'(WE), 64'd0);
    chk("single_idle_t", 64'(idle), 64'd0);
    tick(); #1;
    chk("single_we_t1", 64'(WE), 64'd1);
    chk("single_wa_t1", 64'(WA), 64'd5);
    chk("single_data_t1", 64'(dataIn), 64'hDEADBEEF);
    chk("single_pending_t1", 64'(pending), 64'd0);
    tick(); #1;
    chk("single_we_t2", 64'(WE), 64'd0);
    chk("single_idle_t2", 64'(idle), 64'd1);

    // Hold fills the FIFO; a fifth request waits for space
    br_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(5'(10 + i), 32'hA0 + 32'(i));
    #1;
    chk("hold_full_ready", 64'(req_ready), 64'd0);
    chk("hold_we", 64'(WE), 64'd0);
    chk("hold_pending", 64'(pending), 64'h3C00);
    req_valid = 1'b1; req_addr = 5'd20; req_data = 32'hBB;
    tick(); #1;
    chk("hold_5th_blocked", 64'(req_ready), 64'd0);
    br_hold = 1'b0;
    send(5'd20, 32'hBB);
    #1;
    chk("release_streaming_we", 64'(WE), 64'd1);
    wait_drain();

    // Forwarding: youngest FIFO entry beats older entries and the output stage
    br_hold = 1'b1;
    send(5'd7, 32'h11);
    send(5'd3, 32'h33);
    send(5'd7, 32'h22);
    RA_A = 5'd7; RA_B = 5'd8;
    #1;
    chk("fwd_a_hit", 64'(fwd_hit_a), 64'd1);
    chk("fwd_a_data", 64'(fwd_data_a), 64'h22);
    chk("fwd_b_miss_hit", 64'(fwd_hit_b), 64'd0);
    chk("fwd_b_miss_data", 64'(fwd_data_b), 64'd0);
    chk("fwd_pending", 64'(pending), 64'h88);
    RA_B = 5'd3;
    #1;
    chk("fwd_b3_data", 64'(fwd_data_b), 64'h33);
    br_hold = 1'b0;
    tick(); #1;
    chk("fwd_p1_a", 64'(fwd_data_a), 64'h22);
    chk("fwd_p1_b", 64'(fwd_data_b), 64'h33);
    tick(); #1;
    chk("fwd_p2_a", 64'(fwd_data_a), 64'h22);
    chk("fwd_p2_b_outstage", 64'({fwd_hit_b, fwd_data_b}), 64'h1_0000_0033);
    tick(); #1;
    chk("fwd_p3_a_outstage", 64'({fwd_hit_a, fwd_data_a}), 64'h1_0000_0022);
    chk("fwd_p3_b_gone", 64'({fwd_hit_b, fwd_data_b}), 64'd0);
    tick(); #1;
    chk("fwd_p4_a_gone", 64'({fwd_hit_a, fwd_data_a}), 64'd0);
    RA_A = '0; RA_B = '0;

    // Full with a pop in the same cycle: no pass-through, then wrap many times
    br_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(5'(16 + i), 32'h100 + 32'(i));
    br_hold = 1'b0;
    req_valid = 1'b1; req_addr = 5'd1; req_data = 32'h500;
    #1;
    chk("full_pop_ready_low", 64'(req_ready), 64'd0);
    send(5'd1, 32'h500);
    for (int i = 0; i < 12; i++) begin
      br_hold = ((i % 5) == 3);
      send(5'(i + 1), 32'h1000 + 32'(i));
    end
    br_hold = 1'b0;
    wait_drain();

`ifdef ZERO_REG_DROP_EN
    RA_A = '0;
    send(5'd0, 32'h55);
    #1;
    chk("zdrop_idle", 64'(idle), 64'd1);
    chk("zdrop_pending", 64'(pending), 64'd0);
    chk("zdrop_hit", 64'(fwd_hit_a), 64'd0);
    repeat (3) tick();
    #1;
    chk("zdrop_idle_later", 64'(idle), 64'd1);
`else
    br_hold = 1'b1;
    send(5'd0, 32'h55);
    RA_A = '0;
    #1;
    chk("zreg_pending", 64'(pending), 64'd1);
    chk("zreg_fwd", 64'({fwd_hit_a, fwd_data_a}), 64'h1_0000_0055);
    br_hold = 1'b0;
    wait_drain();
`endif

    // Reset mid-stream discards queued writes
    br_hold = 1'b1;
    send(5'd21, 32'h1);
    send(5'd22, 32'h2);
    send(5'd23, 32'h3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_we", 64'(WE), 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    br_hold = 1'b0;
    repeat (5) tick();
    #1;
    chk("midrst_idle_after", 64'(idle), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
